// File: rtl/echo_ranger.sv
// echo_ranger: ultrasonic range finder. It fires a trigger pulse once per period,
// times the returned echo in microseconds and converts the width to millimetres.
// Optional build macro RANGER_AVG_EN: report the mean of the last 4 good results.
module echo_ranger #(
  parameter int CLK_MHZ    = 50,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo,
  output logic        trig,
  output logic [13:0] distance,
  output logic        valid,
  output logic        timeout
);

  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int PW        = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int CNT_MAX   = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int PERW      = $clog2(PERIOD_US + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CALC} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            echo_prev_q, echo_prev_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PERW-1:0] period_q, period_d;
  logic            start_q, start_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [13:0]     dist_q, dist_d;

  logic            tick;
  logic            echo_rise;
  logic            echo_fall;
  logic [29:0]     prod;
  logic [13:0]     raw_mm;
  logic [13:0]     new_mm;

  // 11239/65536 mm per us approximates half the speed of sound.
  assign prod   = 30'(cnt_q) * 30'd11239;
  assign raw_mm = 14'(prod >> 16);

`ifdef RANGER_AVG_EN
  logic [13:0] hist_q [3];
  logic [13:0] hist_d [3];
  logic [15:0] sum;

  // Sliding window: the new raw result plus the three previous good ones.
  always_comb begin
    sum       = 16'(raw_mm) + 16'(hist_q[0]) + 16'(hist_q[1]) + 16'(hist_q[2]);
    new_mm    = 14'(sum >> 2);
    hist_d[0] = hist_q[0];
    hist_d[1] = hist_q[1];
    hist_d[2] = hist_q[2];
    if (state_q == CALC) begin
      hist_d[0] = raw_mm;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
    end
  end

  // History registers; cleared to zero so early averages ramp up from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
    end else begin
      hist_q[0] <= hist_d[0];
      hist_q[1] <= hist_d[1];
      hist_q[2] <= hist_d[2];
    end
  end
`else
  assign new_mm = raw_mm;
`endif

  // Edges come only from the synchronized copy of the asynchronous echo pin.
  assign echo_rise = sync2_q & ~echo_prev_q;
  assign echo_fall = ~sync2_q & echo_prev_q;
  assign tick      = (presc_q == PW'(CLK_MHZ - 1));

  // Next-state, counter and output logic for the measurement sequencer.
  always_comb begin
    state_d     = state_q;
    sync1_d     = echo;
    sync2_d     = sync1_q;
    echo_prev_d = sync2_q;
    presc_d     = tick ? '0 : presc_q + PW'(1);
    cnt_d       = cnt_q;
    start_d     = start_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    dist_d      = dist_q;
    // Period count saturates one short of the period so a late-finishing
    // measurement triggers again on the next tick after reaching IDLE.
    period_d    = (tick && period_q != PERW'(PERIOD_US - 1)) ? period_q + PERW'(1) : period_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tick && (start_q || period_q == PERW'(PERIOD_US - 1))) begin
          state_d  = TRIG;
          period_d = '0;
          start_d  = 1'b0;
        end
      end
      TRIG: begin
        if (tick) begin
          if (cnt_q == CW'(TRIG_US - 1)) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (tick) begin
          if (cnt_q == CW'(TIMEOUT_US - 1)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_d = CALC;
        end else if (tick) begin
          if (cnt_q == CW'(TIMEOUT_US - 1)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CALC: begin
        dist_d    = new_mm;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      echo_prev_q <= 1'b0;
      presc_q     <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      start_q     <= 1'b1;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      dist_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      echo_prev_q <= echo_prev_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      dist_q      <= dist_d;
    end
  end

  assign trig     = (state_q == TRIG);
  assign distance = dist_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger: directed/random echo sequences checked against a millimetre model.
module tb_echo_ranger;

  localparam int CLK_MHZ    = 2;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 3;
  localparam int TIMEOUT_US = 1200;
  localparam int PER_CLK    = PERIOD_MS * 1000 * CLK_MHZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic        valid;
  logic        timeout;
  logic [13:0] distance;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_valid = 0;
  int valid_cyc = 0;
  int valid_run = 0;
  int max_run = 0;
  int valid_dist = 0;
  int last_rise = 0;
  int exp_dist = 0;
  int exp_to = 0;
  int meas_no = 0;
`ifdef RANGER_AVG_EN
  int hist [4] = '{0, 0, 0, 0};
`endif

  echo_ranger #(
    .CLK_MHZ   (CLK_MHZ),
    .TRIG_US   (TRIG_US),
    .PERIOD_MS (PERIOD_MS),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .echo    (echo),
    .trig    (trig),
    .distance(distance),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Observe valid strobes on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      n_valid    = n_valid + 1;
      valid_cyc  = cyc;
      valid_dist = int'(distance);
      valid_run  = valid_run + 1;
      if (valid_run > max_run) max_run = valid_run;
    end else begin
      valid_run = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: width in us -> mm, optionally averaged over the last 4 good results.
  task automatic model_success(input int w);
    int raw;
    raw = ((w * 11239) >> 16) & 32'h3FFF;
`ifdef RANGER_AVG_EN
    hist[3]  = hist[2];
    hist[2]  = hist[1];
    hist[1]  = hist[0];
    hist[0]  = raw;
    exp_dist = (hist[0] + hist[1] + hist[2] + hist[3]) >> 2;
`else
    exp_dist = raw;
`endif
    exp_to = 0;
  endtask

  task automatic model_reset();
`ifdef RANGER_AVG_EN
    hist = '{0, 0, 0, 0};
`endif
    exp_dist = 0;
    exp_to   = 0;
  endtask

  task automatic wait_rise(input string tag, input int budget, output int waited);
    int c = 0;
    while (trig !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    waited = c;
    check({tag, " trig rise"}, 32'(trig), 32'd1);
  endtask

  // Wait for the next period's trigger; 'exact' when the prescaler phase was untouched.
  task automatic next_period(input string tag, input bit exact);
    int w, iv;
    wait_rise(tag, PER_CLK + CLK_MHZ + 10, w);
    iv = cyc - last_rise;
    last_rise = cyc;
    if (exact) check({tag, " period"}, 32'(iv), 32'(PER_CLK));
    else check({tag, " period window"}, 32'(iv >= PER_CLK && iv < PER_CLK + CLK_MHZ), 32'd1);
  endtask

  task automatic wait_fall(input string tag, input bit chk);
    int c = 0;
    while (trig === 1'b1 && c < TRIG_US * CLK_MHZ * 2 + 10) begin
      step();
      c++;
    end
    if (chk) check({tag, " trig width"}, 32'(c), 32'(TRIG_US * CLK_MHZ));
  endtask

  task automatic do_echo(input string tag, input int delay_us, input int width_us);
    int v0, fall_cyc;
    repeat (delay_us * CLK_MHZ) step();
    echo = 1'b1;
    repeat (width_us * CLK_MHZ + 1) step();
    echo = 1'b0;
    fall_cyc = cyc;
    v0 = n_valid;
    repeat (8) step();
    model_success(width_us);
    check({tag, " valid count"}, 32'(n_valid - v0), 32'd1);
    check({tag, " latency<=5"}, 32'(valid_cyc - fall_cyc <= 5), 32'd1);
    check({tag, " strobe dist"}, 32'(valid_dist), 32'(exp_dist));
    check({tag, " distance"}, 32'(distance), 32'(exp_dist));
    check({tag, " timeout"}, 32'(timeout), 32'(exp_to));
    meas_no++;
    $display("meas %0d %s: delay %0d us width %0d us -> distance %0d timeout %0d",
             meas_no, tag, delay_us, width_us, distance, timeout);
  endtask

  task automatic no_echo(input string tag);
    int v0;
    v0 = n_valid;
    repeat (TIMEOUT_US * CLK_MHZ - 4) step();
    check({tag, " timeout before limit"}, 32'(timeout), 32'(exp_to));
    repeat (14) step();
    exp_to = 1;
    check({tag, " timeout"}, 32'(timeout), 32'd1);
    check({tag, " no valid"}, 32'(n_valid - v0), 32'd0);
    check({tag, " distance held"}, 32'(distance), 32'(exp_dist));
    meas_no++;
    $display("meas %0d %s: no echo -> distance %0d timeout %0d", meas_no, tag, distance, timeout);
  endtask

  initial begin
    int w, v0;
    // Reset state.
    repeat (3) step();
    check("reset trig", 32'(trig), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset distance", 32'(distance), 32'd0);

    // First trigger on the first tick after release, echo absent.
    rst_n = 1'b1;
    wait_rise("first", CLK_MHZ + 4, w);
    check("first trig delay", 32'(w >= 1 && w <= CLK_MHZ), 32'd1);
    last_rise = cyc;
    wait_fall("first", 1'b1);
    no_echo("absent0");

    next_period("p1", 1'b1);
    wait_fall("p1", 1'b1);
    do_echo("echo1000", $urandom_range(0, 200), 1000);

    next_period("p2", 1'b0);
    wait_fall("p2", 1'b0);
    no_echo("absent1");

    // Echo stuck high from before the trigger: never a rise.
    echo = 1'b1;
    next_period("p3", 1'b1);
    wait_fall("p3", 1'b0);
    v0 = n_valid;
    repeat (TIMEOUT_US * CLK_MHZ + 10) step();
    check("stuck timeout", 32'(timeout), 32'd1);
    check("stuck no valid", 32'(n_valid - v0), 32'd0);
    check("stuck distance held", 32'(distance), 32'(exp_dist));
    meas_no++;
    $display("meas %0d stuck: echo high throughout -> distance %0d timeout %0d", meas_no, distance, timeout);
    echo = 1'b0;

    next_period("p4", 1'b1);
    wait_fall("p4", 1'b0);
    do_echo("recover1000", $urandom_range(0, 200), 1000);

    for (int i = 0; i < 3; i++) begin
      next_period("rnd", 1'b0);
      wait_fall("rnd", 1'b0);
      do_echo("random", $urandom_range(0, 200), $urandom_range(1, 1100));
    end

    // Widest width that still completes.
    next_period("p8", 1'b0);
    wait_fall("p8", 1'b0);
    do_echo("maxwidth", 0, TIMEOUT_US - 1);

    // Width overflow: timeout, distance unchanged, no strobe.
    next_period("p9", 1'b0);
    wait_fall("p9", 1'b0);
    repeat (20 * CLK_MHZ) step();
    echo = 1'b1;
    v0 = n_valid;
    repeat ((TIMEOUT_US + 50) * CLK_MHZ) step();
    echo = 1'b0;
    repeat (8) step();
    exp_to = 1;
    check("overflow timeout", 32'(timeout), 32'd1);
    check("overflow no valid", 32'(n_valid - v0), 32'd0);
    check("overflow distance held", 32'(distance), 32'(exp_dist));
    meas_no++;
    $display("meas %0d overflow: width %0d us -> distance %0d timeout %0d",
             meas_no, TIMEOUT_US + 50, distance, timeout);

    // Reset in the middle of a measurement.
    next_period("p10", 1'b0);
    wait_fall("p10", 1'b0);
    repeat (20 * CLK_MHZ) step();
    echo = 1'b1;
    repeat (100 * CLK_MHZ) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset trig", 32'(trig), 32'd0);
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset distance", 32'(distance), 32'(exp_dist));
    check("midreset timeout", 32'(timeout), 32'(exp_to));
    echo = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    wait_rise("rerun", CLK_MHZ + 4, w);
    check("rerun trig delay", 32'(w >= 1 && w <= CLK_MHZ), 32'd1);
    last_rise = cyc;
    wait_fall("rerun", 1'b1);
    do_echo("after_reset", $urandom_range(0, 200), $urandom_range(1, 1100));

    check("valid one cycle", 32'(max_run), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
